dict_match_decoder: RTL and testbench

- Decompression-side counterpart of the compressor's dictionary match search.
- Accepts tokens of two kinds:
  - literal byte;
  - match given as {dict_word_index, local_byte_index} plus a length.
- Replays the referenced bytes out of a local dictionary that mirrors the compressor's 64-byte history.
- Emits one byte per cycle over a valid/ready stream and writes every emitted byte back into the dictionary, so both ends stay in lockstep.

---
 rtl/dict_pkg.sv | 23 ++
 rtl/dict_history_ram.sv | 30 +++
 rtl/dict_match_decoder.sv | 119 +++++++++++
 tb/tb_dict_match_decoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dict_pkg.sv
// Shared types and geometry for the dictionary match decoder: 16 words x 4 bytes,
// addressed by the absolute byte position {word_index, byte_index}.
package dict_pkg;
  localparam int DICT_WORDS     = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int WI_W           = $clog2(DICT_WORDS);
  localparam int BI_W           = $clog2(BYTES_PER_WORD);
  localparam int DEPTH          = DICT_WORDS * BYTES_PER_WORD;
  localparam int PTR_W          = $clog2(DEPTH);
  localparam int LEN_W          = 4;

  typedef logic [PTR_W-1:0] dict_ptr_t;

  typedef struct packed {
    logic             is_literal;
    logic [7:0]       literal;
    logic [WI_W-1:0]  word_index;
    logic [BI_W-1:0]  byte_index;
    logic [LEN_W-1:0] len;
  } dict_token_t;

  typedef enum logic {IDLE, EMIT} dec_state_e;
endpackage

// File: rtl/dict_history_ram.sv
// 64x8 history register array: one write port, one asynchronous read port and a
// synchronous clear that wins over a simultaneous write.
module dict_history_ram
  import dict_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       we,
  input  dict_ptr_t  waddr,
  input  logic [7:0] wdata,
  input  dict_ptr_t  raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Unregistered read so a byte written on the previous edge is visible at once,
  // which is what makes overlapping (run-length) copies exact.
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/dict_match_decoder.sv
// Replays literal/match tokens into a byte stream and mirrors every emitted byte
// into the history. Optional bounds check: define DICT_MATCH_DECODER_BOUNDS_CHECK_EN.
module dict_match_decoder
  import dict_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dict_clear,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_literal,
  input  logic [7:0]       tok_literal,
  input  logic [WI_W-1:0]  tok_word_index,
  input  logic [BI_W-1:0]  tok_byte_index,
  input  logic [LEN_W-1:0] tok_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             busy
`ifdef DICT_MATCH_DECODER_BOUNDS_CHECK_EN
  ,
  output logic             err_unwritten
`endif
);
  dec_state_e       state_q;
  logic             is_lit_q;
  logic [7:0]       lit_q;
  dict_ptr_t        rd_ptr_q;
  dict_ptr_t        wr_ptr_q;
  dict_ptr_t        wr_ptr_d;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] rem_d;
  logic [7:0]       rd_data;
  logic             out_hs;
  dict_token_t      tok_in;
  dict_ptr_t        tok_ptr;

  assign tok_in  = '{is_literal: tok_is_literal, literal: tok_literal,
                     word_index: tok_word_index, byte_index: tok_byte_index,
                     len: tok_len};
  assign tok_ptr = {tok_in.word_index, tok_in.byte_index};

  assign tok_ready = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign out_last  = out_valid && (rem_q == LEN_W'(1));
  assign out_byte  = out_valid ? (is_lit_q ? lit_q : rd_data) : 8'h00;
  assign out_hs    = out_valid && out_ready;

  assign wr_ptr_d  = wr_ptr_q + dict_ptr_t'(1);
  assign rem_d     = (tok_in.is_literal || tok_in.len == '0) ? LEN_W'(1) : tok_in.len;

  dict_history_ram u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dict_clear),
    .we    (out_hs && !dict_clear),
    .waddr (wr_ptr_q),
    .wdata (out_byte),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      is_lit_q <= 1'b0;
      lit_q    <= 8'h00;
      rd_ptr_q <= '0;
      rem_q    <= '0;
    end else if (dict_clear) begin
      state_q  <= IDLE;
      rem_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (tok_valid) begin
          is_lit_q <= tok_in.is_literal;
          lit_q    <= tok_in.literal;
          rd_ptr_q <= tok_ptr;
          rem_q    <= rem_d;
          state_q  <= EMIT;
        end
        EMIT: if (out_ready) begin
          rem_q    <= rem_q - LEN_W'(1);
          rd_ptr_q <= rd_ptr_q + dict_ptr_t'(1);
          if (rem_q == LEN_W'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wr_ptr_q <= '0;
    else if (dict_clear) wr_ptr_q <= '0;
    else if (out_hs)     wr_ptr_q <= wr_ptr_d;
  end

`ifdef DICT_MATCH_DECODER_BOUNDS_CHECK_EN
  logic [PTR_W:0] fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q        <= '0;
      err_unwritten <= 1'b0;
    end else if (dict_clear) begin
      fill_q        <= '0;
      err_unwritten <= 1'b0;
    end else begin
      if (out_hs && fill_q != (PTR_W+1)'(DEPTH)) fill_q <= fill_q + 1'b1;
      // Until the history has filled once, anything at or beyond wr_ptr was never written.
      if (tok_valid && tok_ready && !tok_in.is_literal &&
          fill_q < (PTR_W+1)'(DEPTH) && tok_ptr >= wr_ptr_q)
        err_unwritten <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dict_match_decoder.sv
// Scoreboard bench: a sequential history model predicts each output byte at issue
// time; a negedge monitor pops and compares on every output handshake.
module tb_dict_match_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dict_clear = 1'b0;
  logic       tok_valid = 1'b0;
  logic       tok_ready;
  logic       tok_is_literal = 1'b0;
  logic [7:0] tok_literal = 8'h00;
  logic [3:0] tok_word_index = 4'h0;
  logic [1:0] tok_byte_index = 2'h0;
  logic [3:0] tok_len = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_byte;
  logic       out_last;
  logic       busy;
`ifdef DICT_MATCH_DECODER_BOUNDS_CHECK_EN
  logic       err_unwritten;
`endif

  dict_match_decoder dut (
    .clk(clk), .rst_n(rst_n), .dict_clear(dict_clear),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_literal(tok_is_literal),
    .tok_literal(tok_literal), .tok_word_index(tok_word_index),
    .tok_byte_index(tok_byte_index), .tok_len(tok_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .busy(busy)
`ifdef DICT_MATCH_DECODER_BOUNDS_CHECK_EN
    , .err_unwritten(err_unwritten)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random, 3: never

  logic [8:0] exp_q[$];   // {last, byte}
  logic [7:0] mdict[64];
  int mwr = 0;
  int mfill = 0;
  bit merr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdict[i] = 8'h00;
    mwr = 0; mfill = 0; merr = 0;
  endtask

  task automatic model_emit(input logic [7:0] b, input bit last);
    exp_q.push_back({last, b});
    mdict[mwr] = b;
    mwr = (mwr + 1) % 64;
    if (mfill < 64) mfill++;
  endtask

  task automatic send_token(input bit is_lit, input logic [7:0] lit, input int ptr, input int len);
    int n_eff;
    int n;
    if (is_lit) begin
      model_emit(lit, 1'b1);
    end else begin
      if (mfill < 64 && ptr >= mwr) merr = 1;
      n_eff = (len == 0) ? 1 : len;
      for (int i = 0; i < n_eff; i++) model_emit(mdict[(ptr + i) % 64], i == n_eff - 1);
    end
    @(posedge clk); #1;
    tok_valid      = 1'b1;
    tok_is_literal = is_lit;
    tok_literal    = lit;
    tok_word_index = ptr[5:2];
    tok_byte_index = ptr[1:0];
    tok_len        = len[3:0];
    n = 0;
    while (!tok_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("tok_accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !tok_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_clear();
    @(posedge clk); #2;
    dict_clear = 1'b1;
    @(posedge clk); #2;
    dict_clear = 1'b0;
    model_reset();
  endtask

  task automatic chk_err(input string name);
`ifdef DICT_MATCH_DECODER_BOUNDS_CHECK_EN
    chk(name, 32'(err_unwritten), 32'(merr));
`else
    if (name.len() == 0) $display("unused");
`endif
  endtask

  // Ready generator
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       prev_stall = 1'b0;
    logic       prev_clr = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic       prev_last = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("tok_ready_while_emit", 32'(tok_ready), 32'(!out_valid));
        chk("busy", 32'(busy), 32'(out_valid));
        if (prev_stall && !prev_clr) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_byte", 32'(out_byte), 32'(prev_byte));
          chk("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready && !dict_clear) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'(out_byte), 32'h1ff);
          end else begin
            e = exp_q.pop_front();
            chk("out_byte", 32'(out_byte), 32'(e[7:0]));
            chk("out_last", 32'(out_last), 32'(e[8]));
            $display("out byte=%02h last=%0b expected=%02h/%0b", out_byte, out_last, e[7:0], e[8]);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_byte;
        prev_last  = out_last;
        prev_clr   = dict_clear;
      end
    end
  end

  initial begin
    int base;
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tok_ready", 32'(tok_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_byte", 32'(out_byte), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_err("rst_err");
    rst_n = 1'b1;
    rdy_mode = 0;

    // Literals, then a back-reference, then an overlapping run
    send_token(1, 8'h41, 0, 0);
    send_token(1, 8'h42, 0, 0);
    send_token(1, 8'h43, 0, 0);
    send_token(1, 8'h44, 0, 0);
    send_token(0, 8'h00, 1, 3);
    send_token(1, 8'h5A, 0, 0);
    send_token(0, 8'h00, 7, 5);
    drain();
    chk_err("err_after_basic");

    // Wrap-around of the write pointer
    do_clear();
    for (int i = 0; i < 62; i++) send_token(1, 8'(i), 0, 0);
    send_token(1, 8'hEE, 0, 0);
    send_token(1, 8'hFF, 0, 0);
    send_token(1, 8'h11, 0, 0);
    send_token(0, 8'h00, 62, 4);
    drain();
    chk_err("err_after_wrap");

    // Backpressure: toggled ready on a length-3 match
    rdy_mode = 1;
    base = hs_count;
    send_token(0, 8'h00, 60, 3);
    drain();
    chk("bp_handshakes", 32'(hs_count - base), 32'd3);
    rdy_mode = 0;

    // Length 0 is treated as 1
    send_token(0, 8'h00, 5, 0);
    drain();

    // Clear in the middle of a length-8 match
    base = hs_count;
    send_token(0, 8'h00, 10, 8);
    n = 0;
    while (hs_count < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("clear_wait_timeout", 32'(hs_count - base), 32'd2);
    @(posedge clk); #2;
    rdy_mode = 3;
    out_ready = 1'b0;
    dict_clear = 1'b1;
    @(posedge clk); #2;
    dict_clear = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_tok_ready", 32'(tok_ready), 32'd1);
    chk("clr_abandoned", 32'(exp_q.size()), 32'd6);
    exp_q.delete();
    model_reset();
    rdy_mode = 0;
    send_token(0, 8'h00, 0, 1);
    drain();
    chk_err("err_after_clear");

    // Randomised tokens with random backpressure
    do_clear();
    rdy_mode = 2;
    for (int t = 0; t < 150; t++) begin
      send_token($urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 63), $urandom_range(0, 15));
    end
    drain();
    chk_err("err_after_random");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
